// File: rtl/stdp_pkg.sv
// Shared constants and the exponential step rule for the STDP synapse.
package stdp_pkg;

    localparam int unsigned STDP_CNT_W  = 4;
    localparam int unsigned STDP_W_W    = 8;
    localparam int unsigned STDP_W_INIT = 128;

    localparam logic DIR_LTD = 1'b0;
    localparam logic DIR_LTP = 1'b1;

    // Step halves for every extra cycle of spike separation: amp at dt = 1.
    function automatic int unsigned stdp_delta(input int unsigned amp, input int unsigned dt);
        if (dt == 0) return amp;
        return amp >> (dt - 1);
    endfunction

endpackage

// File: rtl/stdp_synapse_if.sv
// Spike inputs and weight-update outputs of one STDP synapse.
interface stdp_synapse_if #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned W_W   = 8
);
    logic             pre_spike;
    logic             post_spike;
    logic             learn_en;
    logic [W_W-1:0]   weight;
    logic [CNT_W-1:0] time_diff;
    logic             update_w_flag;
    logic             ltp;

    modport master (
        output pre_spike, post_spike, learn_en,
        input  weight, time_diff, update_w_flag, ltp
    );

    modport slave (
        input  pre_spike, post_spike, learn_en,
        output weight, time_diff, update_w_flag, ltp
    );
endinterface

// File: rtl/stdp_synapse_spike_timer.sv
// Saturating interval timer: 0 = no spike yet, loads 1 on a spike, then counts up to all-ones.
module spike_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    output logic [CNT_W-1:0] t
);
    localparam logic [CNT_W-1:0] T_MAX = '1;

    logic [CNT_W-1:0] t_q, t_d;

    always_comb begin
        t_d = t_q;
        if (spike) begin
            t_d = CNT_W'(1);
        end else if (t_q != '0 && t_q != T_MAX) begin
            t_d = t_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) t_q <= '0;
        else     t_q <= t_d;
    end

    assign t = t_q;
endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: spike timers, event detection stage, saturating weight-apply stage.
module stdp_synapse
    import stdp_pkg::*;
#(
    parameter int unsigned CNT_W   = STDP_CNT_W,
    parameter int unsigned W_W     = STDP_W_W,
    parameter int unsigned W_INIT  = STDP_W_INIT,
    parameter int unsigned A_PLUS  = 16,
    parameter int unsigned A_MINUS = 16
) (
    input logic           clk,
    input logic           rst,
    stdp_synapse_if.slave bus
);
    localparam logic [CNT_W-1:0] T_MAX = '1;
    localparam logic [W_W:0]     W_MAX = {1'b0, {W_W{1'b1}}};

    logic [CNT_W-1:0] t_pre, t_post;

    spike_timer #(.CNT_W(CNT_W)) u_pre_timer (
        .clk   (clk),
        .rst   (rst),
        .spike (bus.pre_spike),
        .t     (t_pre)
    );

    spike_timer #(.CNT_W(CNT_W)) u_post_timer (
        .clk   (clk),
        .rst   (rst),
        .spike (bus.post_spike),
        .t     (t_post)
    );

    logic             ltp_evt_c, ltd_evt_c;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_dir_q, s1_dir_d;
    logic [CNT_W-1:0] s1_dt_q, s1_dt_d;

    // Stage 1: classify the spike pair using timer values from before this edge.
    always_comb begin
        ltp_evt_c  = bus.post_spike & ~bus.pre_spike & bus.learn_en
                   & (t_pre != '0) & (t_pre != T_MAX);
        ltd_evt_c  = bus.pre_spike & ~bus.post_spike & bus.learn_en
                   & (t_post != '0) & (t_post != T_MAX);
        s1_valid_d = ltp_evt_c | ltd_evt_c;
        s1_dir_d   = ltp_evt_c ? DIR_LTP : DIR_LTD;
        s1_dt_d    = ltp_evt_c ? t_pre : t_post;
    end

    logic [W_W-1:0]   weight_q, weight_d;
    logic [CNT_W-1:0] time_diff_q, time_diff_d;
    logic             flag_q, flag_d;
    logic             ltp_q, ltp_d;
    logic [W_W:0]     delta_c, sum_c;

    // Stage 2: one extra bit of headroom so overflow and underflow clamp cleanly.
    always_comb begin
        delta_c     = (W_W+1)'(stdp_delta((s1_dir_q == DIR_LTP) ? A_PLUS : A_MINUS,
                                          32'(s1_dt_q)));
        sum_c       = {1'b0, weight_q} + delta_c;
        weight_d    = weight_q;
        time_diff_d = time_diff_q;
        ltp_d       = ltp_q;
        flag_d      = 1'b0;
        if (s1_valid_q) begin
            flag_d      = 1'b1;
            time_diff_d = s1_dt_q;
            ltp_d       = s1_dir_q;
            if (s1_dir_q == DIR_LTP) begin
                weight_d = (sum_c > W_MAX) ? W_MAX[W_W-1:0] : sum_c[W_W-1:0];
            end else begin
                weight_d = (delta_c > {1'b0, weight_q}) ? '0
                                                        : weight_q - delta_c[W_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_dir_q    <= DIR_LTD;
            s1_dt_q     <= '0;
            weight_q    <= W_W'(W_INIT);
            time_diff_q <= '0;
            flag_q      <= 1'b0;
            ltp_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_dir_q    <= s1_dir_d;
            s1_dt_q     <= s1_dt_d;
            weight_q    <= weight_d;
            time_diff_q <= time_diff_d;
            flag_q      <= flag_d;
            ltp_q       <= ltp_d;
        end
    end

    assign bus.weight        = weight_q;
    assign bus.time_diff     = time_diff_q;
    assign bus.update_w_flag = flag_q;
    assign bus.ltp           = ltp_q;
endmodule

// File: tb/tb_stdp_synapse.sv
// Bench for stdp_synapse: directed timing scenarios plus randomized spikes against a spike-time model.
module tb_stdp_synapse;
    import stdp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pre = 1'b0, post = 1'b0, len = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stdp_synapse_if #(.CNT_W(4), .W_W(8)) bus0 ();
    stdp_synapse_if #(.CNT_W(4), .W_W(8)) bus_hi ();
    stdp_synapse_if #(.CNT_W(4), .W_W(8)) bus_lo ();

    assign bus0.pre_spike    = pre;
    assign bus0.post_spike   = post;
    assign bus0.learn_en     = len;
    assign bus_hi.pre_spike  = pre;
    assign bus_hi.post_spike = post;
    assign bus_hi.learn_en   = len;
    assign bus_lo.pre_spike  = pre;
    assign bus_lo.post_spike = post;
    assign bus_lo.learn_en   = len;

    stdp_synapse #(.W_INIT(128)) u_dut (.clk(clk), .rst(rst), .bus(bus0));
    stdp_synapse #(.W_INIT(250)) u_hi  (.clk(clk), .rst(rst), .bus(bus_hi));
    stdp_synapse #(.W_INIT(5))   u_lo  (.clk(clk), .rst(rst), .bus(bus_lo));

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic reset_all();
        pre = 1'b0; post = 1'b0; len = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Advance to the next cycle, apply its inputs; outputs of that cycle are then observable.
    task automatic run_cycle(input logic p, input logic q, input logic l);
        @(posedge clk);
        #1;
        pre = p; post = q; len = l;
    endtask

    task automatic test_reset();
        reset_all();
        checks++; if (bus0.weight !== 8'd128) begin errors++; $display("FAIL rst_weight got %0d exp 128", bus0.weight); end
        checks++; if (bus0.time_diff !== 4'd0) begin errors++; $display("FAIL rst_time_diff got %0d exp 0", bus0.time_diff); end
        checks++; if (bus0.ltp !== 1'b0) begin errors++; $display("FAIL rst_ltp got %0b exp 0", bus0.ltp); end
        checks++; if (bus0.update_w_flag !== 1'b0) begin errors++; $display("FAIL rst_flag got %0b exp 0", bus0.update_w_flag); end
        checks++; if (bus_hi.weight !== 8'd250) begin errors++; $display("FAIL rst_weight_hi got %0d exp 250", bus_hi.weight); end
        checks++; if (bus_lo.weight !== 8'd5) begin errors++; $display("FAIL rst_weight_lo got %0d exp 5", bus_lo.weight); end
    endtask

    task automatic test_ltp_basic();
        reset_all();
        for (int c = 0; c <= 16; c++) begin
            run_cycle(c == 10, c == 12, 1'b1);
            checks++; if (bus0.update_w_flag !== (c == 14)) begin errors++; $display("FAIL ltp_flag c=%0d got %0b exp %0b", c, bus0.update_w_flag, (c == 14)); end
            if (c == 13) begin
                checks++; if (bus0.weight !== 8'd128) begin errors++; $display("FAIL ltp_weight_early got %0d exp 128", bus0.weight); end
            end
            if (c == 14) begin
                checks++; if (bus0.weight !== 8'd136) begin errors++; $display("FAIL ltp_weight got %0d exp 136", bus0.weight); end
                checks++; if (bus0.time_diff !== 4'd2) begin errors++; $display("FAIL ltp_time_diff got %0d exp 2", bus0.time_diff); end
                checks++; if (bus0.ltp !== 1'b1) begin errors++; $display("FAIL ltp_dir got %0b exp 1", bus0.ltp); end
            end
        end
    endtask

    task automatic test_ltd_basic();
        reset_all();
        for (int c = 0; c <= 15; c++) begin
            run_cycle(c == 11, c == 10, 1'b1);
            checks++; if (bus0.update_w_flag !== (c == 13)) begin errors++; $display("FAIL ltd_flag c=%0d got %0b exp %0b", c, bus0.update_w_flag, (c == 13)); end
            if (c == 13) begin
                checks++; if (bus0.weight !== 8'd112) begin errors++; $display("FAIL ltd_weight got %0d exp 112", bus0.weight); end
                checks++; if (bus0.time_diff !== 4'd1) begin errors++; $display("FAIL ltd_time_diff got %0d exp 1", bus0.time_diff); end
                checks++; if (bus0.ltp !== 1'b0) begin errors++; $display("FAIL ltd_dir got %0b exp 0", bus0.ltp); end
            end
        end
    endtask

    task automatic test_coincident();
        reset_all();
        for (int c = 0; c <= 17; c++) begin
            run_cycle(c == 10, c == 10 || c == 13, 1'b1);
            checks++; if (bus0.update_w_flag !== (c == 15)) begin errors++; $display("FAIL coinc_flag c=%0d got %0b exp %0b", c, bus0.update_w_flag, (c == 15)); end
            if (c == 14) begin
                checks++; if (bus0.weight !== 8'd128) begin errors++; $display("FAIL coinc_weight_hold got %0d exp 128", bus0.weight); end
            end
            if (c == 15) begin
                checks++; if (bus0.weight !== 8'd132) begin errors++; $display("FAIL coinc_weight got %0d exp 132", bus0.weight); end
                checks++; if (bus0.time_diff !== 4'd3) begin errors++; $display("FAIL coinc_time_diff got %0d exp 3", bus0.time_diff); end
            end
        end
    endtask

    // Pairs 18 cycles apart so the opposite timer has saturated before the next pair.
    task automatic test_saturation();
        reset_all();
        for (int c = 0; c < 54; c++) begin
            run_cycle(c % 18 == 0, c % 18 == 1, 1'b1);
            checks++; if (bus_hi.update_w_flag !== (c % 18 == 3)) begin errors++; $display("FAIL sat_hi_flag c=%0d got %0b exp %0b", c, bus_hi.update_w_flag, (c % 18 == 3)); end
            if (c % 18 == 3) begin
                checks++; if (bus_hi.weight !== 8'd255) begin errors++; $display("FAIL sat_hi_weight c=%0d got %0d exp 255", c, bus_hi.weight); end
            end
        end
        checks++; if (bus_lo.weight !== 8'd53) begin errors++; $display("FAIL sat_lo_ltp_sum got %0d exp 53", bus_lo.weight); end
        reset_all();
        for (int c = 0; c < 54; c++) begin
            run_cycle(c % 18 == 1, c % 18 == 0, 1'b1);
            checks++; if (bus_lo.update_w_flag !== (c % 18 == 3)) begin errors++; $display("FAIL sat_lo_flag c=%0d got %0b exp %0b", c, bus_lo.update_w_flag, (c % 18 == 3)); end
            if (c % 18 == 3) begin
                checks++; if (bus_lo.weight !== 8'd0) begin errors++; $display("FAIL sat_lo_weight c=%0d got %0d exp 0", c, bus_lo.weight); end
            end
        end
        checks++; if (bus_hi.weight !== 8'd202) begin errors++; $display("FAIL sat_hi_ltd_sum got %0d exp 202", bus_hi.weight); end
    endtask

    task automatic test_window();
        reset_all();
        for (int c = 0; c <= 24; c++) begin
            run_cycle(c == 0, c == 20, 1'b1);
            checks++; if (bus0.update_w_flag !== 1'b0) begin errors++; $display("FAIL win_sat_flag c=%0d got %0b exp 0", c, bus0.update_w_flag); end
        end
        checks++; if (bus0.weight !== 8'd128) begin errors++; $display("FAIL win_sat_weight got %0d exp 128", bus0.weight); end
        reset_all();
        for (int c = 0; c <= 10; c++) begin
            run_cycle(c == 0, c == 6, 1'b1);
            checks++; if (bus0.update_w_flag !== (c == 8)) begin errors++; $display("FAIL win_zero_flag c=%0d got %0b exp %0b", c, bus0.update_w_flag, (c == 8)); end
            if (c == 8) begin
                checks++; if (bus0.weight !== 8'd128) begin errors++; $display("FAIL win_zero_weight got %0d exp 128", bus0.weight); end
                checks++; if (bus0.time_diff !== 4'd6) begin errors++; $display("FAIL win_zero_time_diff got %0d exp 6", bus0.time_diff); end
            end
        end
        reset_all();
        for (int c = 0; c <= 6; c++) begin
            run_cycle(c == 0, c == 2, 1'b0);
            checks++; if (bus0.update_w_flag !== 1'b0) begin errors++; $display("FAIL learn_off_flag c=%0d got %0b exp 0", c, bus0.update_w_flag); end
        end
        checks++; if (bus0.weight !== 8'd128) begin errors++; $display("FAIL learn_off_weight got %0d exp 128", bus0.weight); end
    endtask

    task automatic test_reset_midpipe();
        reset_all();
        for (int c = 0; c <= 24; c++) begin
            run_cycle(c == 10, c == 11 || c == 20, 1'b1);
            if (c == 12) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
                checks++; if (u_dut.t_pre !== 4'd0 || u_dut.t_post !== 4'd0) begin errors++; $display("FAIL midrst_timers got %0d/%0d exp 0/0", u_dut.t_pre, u_dut.t_post); end
            end
            checks++; if (bus0.update_w_flag !== 1'b0) begin errors++; $display("FAIL midrst_flag c=%0d got %0b exp 0", c, bus0.update_w_flag); end
        end
        checks++; if (bus0.weight !== 8'd128) begin errors++; $display("FAIL midrst_weight got %0d exp 128", bus0.weight); end
    endtask

    typedef struct {
        int due;
        bit dir;
        int dt;
    } ev_t;

    // Model works from absolute spike times; events land two cycles after detection.
    task automatic test_back_to_back();
        ev_t pend[$];
        ev_t e;
        int  m_w = 128, m_td = 0;
        bit  m_ltp = 0, m_flag;
        int  last_pre = -1, last_post = -1;
        int  tp, tq;
        bit  p, q, l;
        reset_all();
        for (int c = 0; c < 600; c++) begin
            p = ($urandom_range(0, 2) == 0);
            q = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 7) != 0);
            run_cycle(p, q, l);
            m_flag = 0;
            if (pend.size() > 0 && pend[0].due == c) begin
                e = pend.pop_front();
                m_flag = 1;
                m_td = e.dt;
                m_ltp = e.dir;
                if (e.dir) m_w = (m_w + int'(stdp_delta(16, e.dt)) > 255) ? 255 : m_w + int'(stdp_delta(16, e.dt));
                else       m_w = (m_w - int'(stdp_delta(16, e.dt)) < 0) ? 0 : m_w - int'(stdp_delta(16, e.dt));
            end
            checks++; if (bus0.update_w_flag !== m_flag) begin errors++; $display("FAIL rnd_flag c=%0d got %0b exp %0b", c, bus0.update_w_flag, m_flag); end
            checks++; if (bus0.weight !== 8'(m_w)) begin errors++; $display("FAIL rnd_weight c=%0d got %0d exp %0d", c, bus0.weight, m_w); end
            checks++; if (bus0.time_diff !== 4'(m_td)) begin errors++; $display("FAIL rnd_time_diff c=%0d got %0d exp %0d", c, bus0.time_diff, m_td); end
            checks++; if (bus0.ltp !== m_ltp) begin errors++; $display("FAIL rnd_ltp c=%0d got %0b exp %0b", c, bus0.ltp, m_ltp); end
            tp = (last_pre < 0) ? 0 : ((c - last_pre > 15) ? 15 : c - last_pre);
            tq = (last_post < 0) ? 0 : ((c - last_post > 15) ? 15 : c - last_post);
            if (q && !p && l && tp >= 1 && tp < 15) pend.push_back('{due: c + 2, dir: 1'b1, dt: tp});
            if (p && !q && l && tq >= 1 && tq < 15) pend.push_back('{due: c + 2, dir: 1'b0, dt: tq});
            if (p) last_pre = c;
            if (q) last_post = c;
        end
    endtask

    initial begin
        test_reset();
        test_ltp_basic();
        test_ltd_basic();
        test_coincident();
        test_saturation();
        test_window();
        test_reset_midpipe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
